// File: rtl/dm_lsu_pkg.sv
// ============================================================================
// Module   : dm_lsu_pkg
// Brief    : Shared size encodings, FSM state type and default widths for the
//            dm_lsu load/store initiator.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package dm_lsu_pkg;

    localparam int DM_LSU_AW   = 5;
    localparam int DM_LSU_XLEN = 32;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        ST_W   = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        ERR    = 3'd5
    } lsu_state_t;

    // Encoding 2'b11 is handled as a full word, so only bit 1 matters.
    function automatic logic size_is_word(input logic [1:0] size);
        return size[1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/dm_lsu_align.sv
// ============================================================================
// Module   : dm_lsu_align
// Brief    : Combinational lane logic: load byte/half select with sign/zero
//            extension, and store merge of new data into an old word.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dm_lsu_align
    import dm_lsu_pkg::*;
#(
    parameter int XLEN = DM_LSU_XLEN
) (
    input  logic [1:0]      i_size,
    input  logic [1:0]      i_off,
    input  logic            i_unsigned,
    input  logic [XLEN-1:0] i_rd,
    input  logic [XLEN-1:0] i_old,
    input  logic [XLEN-1:0] i_wdata,
    output logic [XLEN-1:0] o_load,
    output logic [XLEN-1:0] o_merge
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rd[{i_off, 3'b000} +: 8];
        w_half = i_rd[{i_off[1], 4'b0000} +: 16];

        case (i_size)
            SZ_B:    o_load = i_unsigned ? {{(XLEN-8){1'b0}}, w_byte}
                                         : {{(XLEN-8){w_byte[7]}}, w_byte};
            SZ_H:    o_load = i_unsigned ? {{(XLEN-16){1'b0}}, w_half}
                                         : {{(XLEN-16){w_half[15]}}, w_half};
            default: o_load = i_rd;
        endcase

        // Only the addressed lane changes; the rest of the old word passes through.
        o_merge = i_old;
        case (i_size)
            SZ_B:    o_merge[{i_off, 3'b000} +: 8]     = i_wdata[7:0];
            SZ_H:    o_merge[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
            default: o_merge = i_wdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dm_lsu.sv
// ============================================================================
// Module   : dm_lsu
// Brief    : Load/store initiator converting byte/half/word requests into word
//            accesses on a 32-word data memory port (read-modify-write for
//            sub-word stores). Optional macro DM_LSU_MISALIGN_CHECK_EN turns
//            misaligned requests into error responses instead of truncating.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dm_lsu
    import dm_lsu_pkg::*;
#(
    parameter int AW   = DM_LSU_AW,
    parameter int XLEN = DM_LSU_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [31:0]     req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            dm_we,
    output logic [AW-1:0]   dm_addr,
    output logic [XLEN-1:0] dm_wd,
    input  logic [XLEN-1:0] dm_rd
);

    lsu_state_t      r_state;
    lsu_state_t      w_state_nxt;
    logic [AW-1:0]   r_idx;
    logic [1:0]      r_off;
    logic [1:0]      r_size;
    logic            r_we;
    logic            r_unsigned;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_old;

    logic            w_accept;
    logic [1:0]      w_off_nat;
    logic [XLEN-1:0] w_load_data;
    logic [XLEN-1:0] w_merge_data;
    logic            w_resp_valid;
    logic [XLEN-1:0] w_rdata;
    logic            w_we;
    logic [XLEN-1:0] w_wd;
    logic            w_unused_addr;

    assign w_unused_addr = ^req_addr[31:AW+2];

    assign req_ready = (r_state == IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;

    // Offset forced to natural alignment; aligned requests are unaffected.
    always_comb begin
        if (size_is_word(req_size))
            w_off_nat = 2'b00;
        else if (req_size == SZ_H)
            w_off_nat = {req_addr[1], 1'b0};
        else
            w_off_nat = req_addr[1:0];
    end

`ifdef DM_LSU_MISALIGN_CHECK_EN
    logic w_misaligned;
    logic w_err;

    assign w_misaligned = ((req_size == SZ_H) && req_addr[0]) ||
                          (size_is_word(req_size) && (req_addr[1:0] != 2'b00));
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
`ifdef DM_LSU_MISALIGN_CHECK_EN
                    if (w_misaligned)
                        w_state_nxt = ERR;
                    else
`endif
                    if (!req_we)
                        w_state_nxt = LOAD;
                    else if (size_is_word(req_size))
                        w_state_nxt = ST_W;
                    else
                        w_state_nxt = RMW_RD;
                end
            end
            RMW_RD:  w_state_nxt = RMW_WR;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_resp_valid = 1'b0;
        w_rdata      = '0;
        w_we         = 1'b0;
        w_wd         = '0;
`ifdef DM_LSU_MISALIGN_CHECK_EN
        w_err        = 1'b0;
`endif
        case (r_state)
            LOAD: begin
                w_resp_valid = 1'b1;
                w_rdata      = r_we ? '0 : w_load_data;
            end
            ST_W: begin
                w_resp_valid = 1'b1;
                w_we         = 1'b1;
                w_wd         = r_wdata;
            end
            RMW_WR: begin
                w_resp_valid = 1'b1;
                w_we         = 1'b1;
                w_wd         = w_merge_data;
            end
`ifdef DM_LSU_MISALIGN_CHECK_EN
            ERR: begin
                w_resp_valid = 1'b1;
                w_err        = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Gating by rst guarantees no memory write or response in a reset cycle.
    assign resp_valid = w_resp_valid && !rst;
    assign resp_rdata = rst ? '0 : w_rdata;
    assign dm_we      = w_we && !rst;
    assign dm_wd      = rst ? '0 : w_wd;
    assign dm_addr    = r_idx;
`ifdef DM_LSU_MISALIGN_CHECK_EN
    assign resp_err   = w_err && !rst;
`else
    assign resp_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_off      <= '0;
            r_size     <= '0;
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_wdata    <= '0;
            r_old      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_idx      <= req_addr[AW+1:2];
                r_off      <= w_off_nat;
                r_size     <= req_size;
                r_we       <= req_we;
                r_unsigned <= req_unsigned;
                r_wdata    <= req_wdata;
            end
            if (r_state == RMW_RD)
                r_old <= dm_rd;
        end
    end

    dm_lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .i_size     (r_size),
        .i_off      (r_off),
        .i_unsigned (r_unsigned),
        .i_rd       (dm_rd),
        .i_old      (r_old),
        .i_wdata    (r_wdata),
        .o_load     (w_load_data),
        .o_merge    (w_merge_data)
    );

endmodule

`default_nettype wire

// File: tb/tb_dm_lsu.sv
// ============================================================================
// Module   : tb_dm_lsu
// Brief    : Directed self-checking bench for dm_lsu with a 32-word memory model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dm_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        dm_we;
    logic [4:0]  dm_addr;
    logic [31:0] dm_wd;
    logic [31:0] dm_rd;

    logic [31:0] mem [0:31];
    logic        pl_en = 1'b0;
    logic [4:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    int n_vec = 0;
    int n_err = 0;
    int we_count = 0;
    int we_base;

    always #5 clk = ~clk;

    dm_lsu u_dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .dm_we        (dm_we),
        .dm_addr      (dm_addr),
        .dm_wd        (dm_wd),
        .dm_rd        (dm_rd)
    );

    assign dm_rd = mem[dm_addr];

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_addr] <= pl_data;
        else if (dm_we === 1'b1)
            mem[dm_addr] <= dm_wd;
        if (dm_we === 1'b1)
            we_count <= we_count + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    // Drives one request, checks it is accepted, then scrambles the inputs.
    task automatic issue(input string tag, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size;
        req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        #1 chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'hFFFF_FFFF; req_wdata = 32'hDEAD_BEEF;
    endtask

    task automatic do_load(input string tag, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] exp);
        issue(tag, 1'b0, size, uns, addr, 32'h0);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, "_rdata"}, resp_rdata, exp);
        chk({tag, "_we"},    32'(dm_we), 32'd0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_ready",  32'(req_ready),  32'd1);
        chk("idle_valid",  32'(resp_valid), 32'd0);
        chk("idle_rdata",  resp_rdata,      32'd0);
        chk("idle_err",    32'(resp_err),   32'd0);
        chk("idle_we",     32'(dm_we),      32'd0);
        chk("idle_addr",   32'(dm_addr),    32'd0);
        chk("idle_wd",     dm_wd,           32'd0);

        // Word load
        preload(5'd1, 32'h1231_1111);
        we_base = we_count;
        do_load("lw04", 2'b10, 1'b0, 32'h04, 32'h1231_1111);
        chk("lw04_nowrite", 32'(we_count), 32'(we_base));

        // Sub-word loads with extension, issued back to back
        preload(5'd4, 32'h8000_FF7F);
        do_load("lb10",  2'b00, 1'b0, 32'h10, 32'h0000_007F);
        do_load("lb11",  2'b00, 1'b0, 32'h11, 32'hFFFF_FFFF);
        do_load("lbu11", 2'b00, 1'b1, 32'h11, 32'h0000_00FF);
        do_load("lh12",  2'b01, 1'b0, 32'h12, 32'hFFFF_8000);
        do_load("lhu12", 2'b01, 1'b1, 32'h12, 32'h0000_8000);
        do_load("lw_hi", 2'b11, 1'b0, 32'hABC0_0010, 32'h8000_FF7F);

        // Word store
        we_base = we_count;
        issue("sw08", 1'b1, 2'b10, 1'b0, 32'h08, 32'h0563_3453);
        @(negedge clk);
        chk("sw08_we",    32'(dm_we),      32'd1);
        chk("sw08_addr",  32'(dm_addr),    32'd2);
        chk("sw08_wd",    dm_wd,           32'h0563_3453);
        chk("sw08_valid", 32'(resp_valid), 32'd1);
        chk("sw08_rdata", resp_rdata,      32'd0);
        @(negedge clk);
        chk("sw08_we_off", 32'(dm_we), 32'd0);
        chk("sw08_count",  32'(we_count - we_base), 32'd1);
        do_load("lw08", 2'b10, 1'b0, 32'h08, 32'h0563_3453);

        // Byte store via read-modify-write
        preload(5'd1, 32'h1231_1111);
        issue("sb05", 1'b1, 2'b00, 1'b0, 32'h05, 32'h0000_00AB);
        @(negedge clk);
        chk("sb05_t1_we",    32'(dm_we),      32'd0);
        chk("sb05_t1_valid", 32'(resp_valid), 32'd0);
        chk("sb05_t1_ready", 32'(req_ready),  32'd0);
        chk("sb05_t1_addr",  32'(dm_addr),    32'd1);
        @(negedge clk);
        chk("sb05_t2_we",    32'(dm_we),      32'd1);
        chk("sb05_t2_wd",    dm_wd,           32'h1231_AB11);
        chk("sb05_t2_valid", 32'(resp_valid), 32'd1);
        chk("sb05_t2_addr",  32'(dm_addr),    32'd1);

        // Halfword store via read-modify-write
        issue("sh06", 1'b1, 2'b01, 1'b0, 32'h06, 32'h0000_BEEF);
        @(negedge clk);
        @(negedge clk);
        chk("sh06_wd", dm_wd, 32'hBEEF_AB11);
        @(negedge clk);
        chk("sh06_mem", mem[1], 32'hBEEF_AB11);

        // Misaligned accesses
        preload(5'd0, 32'h9ABC_1234);
        we_base = we_count;
`ifdef DM_LSU_MISALIGN_CHECK_EN
        issue("lh03", 1'b0, 2'b01, 1'b0, 32'h03, 32'h0);
        @(negedge clk);
        chk("lh03_valid", 32'(resp_valid), 32'd1);
        chk("lh03_err",   32'(resp_err),   32'd1);
        chk("lh03_rdata", resp_rdata,      32'd0);
        chk("lh03_we",    32'(dm_we),      32'd0);
        issue("lw06", 1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
        @(negedge clk);
        chk("lw06_err", 32'(resp_err), 32'd1);
        issue("sh05", 1'b1, 2'b01, 1'b0, 32'h05, 32'h0000_1357);
        @(negedge clk);
        chk("sh05_err", 32'(resp_err), 32'd1);
        chk("sh05_we",  32'(dm_we),    32'd0);
        @(negedge clk);
        chk("mis_nowrite", 32'(we_count), 32'(we_base));
        chk("mis_mem1",    mem[1],        32'hBEEF_AB11);
`else
        do_load("lh03", 2'b01, 1'b0, 32'h03, 32'hFFFF_9ABC);
        chk("lh03_err", 32'(resp_err), 32'd0);
        do_load("lw06", 2'b10, 1'b0, 32'h06, 32'hBEEF_AB11);
        chk("mis_nowrite", 32'(we_count), 32'(we_base));
`endif

        // Reset in the RMW write cycle abandons the store
        we_base = we_count;
        issue("sb05r", 1'b1, 2'b00, 1'b0, 32'h05, 32'h0000_0055);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rmwrst_we",    32'(dm_we),      32'd0);
        chk("rmwrst_valid", 32'(resp_valid), 32'd0);
        chk("rmwrst_ready", 32'(req_ready),  32'd0);
        @(negedge clk);
        chk("rst_addr",  32'(dm_addr),    32'd0);
        chk("rst_wd",    dm_wd,           32'd0);
        chk("rst_rdata", resp_rdata,      32'd0);
        chk("rst_err",   32'(resp_err),   32'd0);
        rst = 1'b0;
        #1;
        chk("rst_ready_after", 32'(req_ready), 32'd1);
        chk("rst_mem1",        mem[1],         32'hBEEF_AB11);
        chk("rst_nowrite",     32'(we_count),  32'(we_base));

        // Operation resumes normally after reset
        do_load("lb07", 2'b00, 1'b0, 32'h07, 32'hFFFF_FFBE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
